// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmitter arbiter: one-hot FSM encoding,
// the transmitter byte width and an index-width helper.
package uart_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_LAUNCH    = 4'b0010,
    ST_WAIT_DONE = 4'b0100,
    ST_GAP       = 4'b1000
  } arb_state_t;

  localparam int UART_DATA_W = 8;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Client-side and transmitter-side byte handshakes of the UART arbiter.
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);
  import uart_arb_pkg::*;

  // cli_req[i] is a level held until the one-cycle cli_grant[i] pulse that
  // consumes cli_data byte i; tx_req is a one-cycle launch with tx_data held
  // until the transmitter answers with a one-cycle tx_done.
  logic [NUM_REQ-1:0]             cli_req;
  logic [UART_DATA_W*NUM_REQ-1:0] cli_data;
  logic [NUM_REQ-1:0]             cli_grant;
  logic                           tx_req;
  logic [UART_DATA_W-1:0]         tx_data;
  logic                           tx_done;

  modport master (
    input  cli_req, cli_data, tx_done,
    output cli_grant, tx_req, tx_data
  );

  modport slave (
    output cli_req, cli_data, tx_done,
    input  cli_grant, tx_req, tx_data
  );

endinterface

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, with
// wrap-around; reusable for any shared peripheral.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sequencer sharing one 8N1 UART byte transmitter among NUM_REQ
// clients. Optional WAIT_DONE watchdog enabled by macro UART_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  uart_tx_arb_if.master bus,
  output logic          busy,
  output logic [2:0]    cur_owner,
  output logic          tx_err,
  output arb_state_t    fsm_state
);

  localparam int PW = idx_w(NUM_REQ);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  arb_state_t           state;
  logic [PW-1:0]        rr_ptr;
  logic [GW-1:0]        gap_cnt;
  logic [NUM_REQ-1:0]   win_grant;
  logic [PW-1:0]        win_idx;
  logic                 win_any;
  logic [PW-1:0]        next_ptr;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (bus.cli_req),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign next_ptr  = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign fsm_state = state;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
`else
  assign tx_err = 1'b0;
`endif

  // tx_req and cli_grant are registered on the IDLE->LAUNCH edge so they are
  // high for exactly the LAUNCH cycle.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      gap_cnt       <= '0;
      bus.cli_grant <= '0;
      bus.tx_req    <= 1'b0;
      bus.tx_data   <= '0;
      busy          <= 1'b0;
      cur_owner     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_cnt        <= '0;
      tx_err        <= 1'b0;
`endif
    end else begin
      bus.cli_grant <= '0;
      bus.tx_req    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (win_any) begin
            cur_owner     <= 3'(win_idx);
            bus.tx_data   <= bus.cli_data[win_idx*UART_DATA_W +: UART_DATA_W];
            rr_ptr        <= next_ptr;
            bus.cli_grant <= win_grant;
            bus.tx_req    <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
`ifdef UART_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.tx_done) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
`ifdef UART_ARB_TIMEOUT_EN
          // Byte is abandoned; the client was already granted.
          else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
            tx_err  <= 1'b1;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one UART byte transmitter (8N1, one request pulse per byte, one done pulse per byte) among NUM_REQ byte-producing clients.
- Sits between client logic (status reporters, debug dumpers, loopback) and the transmitter.
- Selects one client, launches one byte, waits for the transmitter's done pulse, enforces an inter-byte gap, then rotates priority.

Parameters:
- NUM_REQ, 4, number of requesting clients (2..8).
- GAP_CYCLES, 2, idle cycles after tx_done before the next launch (min 2; the transmitter's done precedes its return to idle by one cycle and its request is registered).
- TIMEOUT_CYCLES, 200000, watchdog limit in sys_clk cycles; used only with UART_ARB_TIMEOUT_EN.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- cli_req  in  NUM_REQ  per-client level request; must hold until granted.
- cli_data  in  8*NUM_REQ  per-client byte; client i occupies bits [8i+7:8i]; stable while cli_req[i]=1.
- cli_grant  out  NUM_REQ  one-hot, one-cycle pulse; byte consumed.
- tx_req  out  1  one-cycle launch pulse to the transmitter.
- tx_data  out  8  byte to the transmitter; held from launch until tx_done.
- tx_done  in  1  one-cycle pulse from the transmitter at end of stop bit.
- busy  out  1  high in every state except IDLE.
- cur_owner  out  3  index of the client currently being served; valid while busy.
- tx_err  out  1  sticky timeout flag; constant 0 without UART_ARB_TIMEOUT_EN.

Behaviour:
- Reset: asynchronous on rst_n low, released on sys_clk.
  - Values: state=IDLE, rr_ptr=0, cli_grant=0, tx_req=0, tx_data=0, busy=0, cur_owner=0, tx_err=0, counters=0.
- Reset mid-byte: the block abandons the byte. The client is not re-granted. The transmitter is expected to share rst_n.
- Arbitration:
  - Search starts at rr_ptr and wraps modulo NUM_REQ. The first index with cli_req set wins.
  - On grant, rr_ptr becomes (winner+1) mod NUM_REQ.
  - Requests are sampled only in IDLE. Requests raised during a byte wait until the next IDLE.
- State IDLE:
  - If any cli_req is set, register the winner into cur_owner and its byte into tx_data, then go to LAUNCH.
  - Otherwise stay in IDLE.
- State LAUNCH (1 cycle):
  - Assert tx_req=1 and cli_grant[cur_owner]=1 in the same cycle, then go to WAIT_DONE.
  - The client may change data or deassert req from the next cycle.
- State WAIT_DONE:
  - Hold tx_data.
  - On tx_done=1, clear the gap counter and go to GAP.
  - A tx_done arriving in IDLE or GAP is ignored.
- State GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - Minimum spacing from tx_done to the next tx_req is GAP_CYCLES+2 cycles (GAP, IDLE, LAUNCH).
- Latency: cli_req rising in IDLE gives cli_grant/tx_req 2 cycles later (IDLE register, LAUNCH).
- Simultaneous requests are resolved by rr_ptr only. No starvation: each waiting client is served within NUM_REQ bytes.
- A cli_req dropped before grant is legal. The client simply loses its turn if absent at IDLE sampling.
- Widths: cur_owner is zero-extended to 3 bits. Gap and timeout counters are sized with $clog2 of their limits.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT_DONE.
  - Reaching TIMEOUT_CYCLES without tx_done sets tx_err=1 (sticky until reset) and forces GAP.
  - The byte is lost; the grant was already given.
- Undefined: no counter; tx_err is tied to 0; WAIT_DONE waits indefinitely.

Decomposition:
- Package uart_arb_pkg:
  - State encodings: one-hot 4-bit IDLE=0001, LAUNCH=0010, WAIT_DONE=0100, GAP=1000.
  - Constant for the transmitter's UART data width, 8.
- Sub-module rr_arbiter (combinational priority rotate: req vector plus pointer in, one-hot winner plus index out). It is reusable for other shared peripherals.
- The FSM, counters and datapath registers live in uart_tx_arb.

Test Plan:
- Single client: cli_req[0]=1, data 0x55 -> grant[0] and tx_req pulse 2 cycles later; tx_data=0x55 held until tx_done; busy low GAP_CYCLES+1 cycles after done.
- All four clients requesting continuously, data 0xA0..0xA3 -> tx_data sequence A0,A1,A2,A3,A0 and grants one-hot in order 0,1,2,3,0.
- Client 2 raises req during a byte owned by client 0 -> served next; rr_ptr becomes 3; no tx_req while in WAIT_DONE or GAP.
- Spurious tx_done pulse in IDLE with no requests -> no state change, no tx_req, busy=0.
- rst_n low for 3 cycles during WAIT_DONE (client 1 active) -> all outputs at reset values immediately; after release, client 1 still requesting is granted afresh (rr_ptr=0 search).
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, tx_done held low -> tx_err=1 at cycle 100 of WAIT_DONE; FSM returns to IDLE after the gap; next client is launched normally.
